// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// nibble_serial_adder_ctrl_pkg: shared state enum, nibble width and counter-width helper
package nibble_serial_adder_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLE_W = 4;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// nibble_serial_adder_ctrl_if: request (in_valid/in_ready/a/b/sub) and result (out_valid/out_ready/sum/cout/ovf/busy) bundle; slave = controller side
interface nibble_serial_adder_ctrl_if
  import nibble_serial_adder_ctrl_pkg::*;
#(parameter int NIBBLES = 4);
  localparam int W = NIBBLE_W * NIBBLES;
  logic in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, busy;
  logic [W-1:0] a, b, sum;
  modport master (output in_valid, a, b, sub, out_ready, input in_ready, out_valid, sum, cout, ovf, busy);
  modport slave (input in_valid, a, b, sub, out_ready, output in_ready, out_valid, sum, cout, ovf, busy);
endinterface

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// nibble_adder_slice: combinational 4-bit ripple-carry adder (a, b, cin -> sum, cout) from four full-adder cells
module nibble_adder_slice
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  logic [NIBBLE_W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: W-bit add/sub one nibble per cycle on a shared slice; ports clk, rst_n (async, active-low), bus (slave)
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(parameter int NIBBLES = 4) (
  input logic clk,
  input logic rst_n,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int W = NIBBLE_W * NIBBLES;
  localparam int CW = cnt_w(NIBBLES);
  state_t state, state_n;
  logic [W-1:0] opa, opb, sum_r, sum_nx, sum_q;
  logic [NIBBLE_W-1:0] s_sum;
  logic [CW-1:0] cnt;
  logic carry, s_cout, a_msb, b_msb, cout_q, ovf_q, last;
  nibble_adder_slice u_slice (.a(opa[NIBBLE_W-1:0]), .b(opb[NIBBLE_W-1:0]), .cin(carry), .sum(s_sum), .cout(s_cout));
  assign sum_nx = W'({s_sum, sum_r} >> NIBBLE_W);
  assign last = cnt == CW'(NIBBLES - 1);
  always_comb
    state_n = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
              state == DONE ? (bus.out_ready ? IDLE : DONE) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      opa <= '0;
      opb <= '0;
      sum_r <= '0;
      sum_q <= '0;
      cnt <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      opa <= bus.a;
      opb <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub;
      cnt <= '0;
      a_msb <= bus.a[W-1];
      b_msb <= bus.sub ? ~bus.b[W-1] : bus.b[W-1];
    end else if (state == RUN) begin
      opa <= opa >> NIBBLE_W;
      opb <= opb >> NIBBLE_W;
      carry <= s_cout;
      cnt <= cnt + 1'b1;
      sum_r <= sum_nx;
      if (last) begin
        sum_q <= sum_nx;
        cout_q <= s_cout;
        ovf_q <= (a_msb == b_msb) && (s_sum[NIBBLE_W-1] != a_msb);
      end
    end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: scoreboard bench with directed and random add/sub requests against an arithmetic model
module tb_nibble_serial_adder_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 16;
  typedef struct {
    logic [W-1:0] s;
    logic c;
    logic o;
    int acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  nibble_serial_adder_ctrl_if #(.NIBBLES(NIBBLES)) bus();
  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_t q[$];
  exp_t e;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic ov_seen = 1'b0;
  logic rnd_bp = 1'b0;
  logic [W-1:0] s0;
  logic c0, o0;
  logic [W-1:0] da[5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005};
  logic [W-1:0] db[5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0001, 16'h0007};
  logic ds[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int acc);
    exp_t r;
    int sa, sb, sr;
    sa = $signed(a);
    sb = $signed(b);
    sr = s ? sa - sb : sa + sb;
    r.s = W'(s ? int'(a) - int'(b) : int'(a) + int'(b));
    r.c = s ? (a >= b) : (int'(a) + int'(b) > 65535);
    r.o = sr > 32767 || sr < -32768;
    r.acc = acc;
    return r;
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.sub, cyc));
  end
  always @(negedge clk) begin
    if (!rst_n) ov_seen = 1'b0;
    else if (bus.out_valid) begin
      if (q.size() == 0) begin
        if (bus.out_ready) timeout("unexpected_result");
      end else begin
        if (!ov_seen) chk("latency", cyc - q[0].acc, NIBBLES);
        ov_seen = 1'b1;
        if (bus.out_ready) begin
          e = q.pop_front();
          chk("sum", bus.sum, e.s);
          chk("cout", bus.cout, e.c);
          chk("ovf", bus.ovf, e.o);
          ov_seen = 1'b0;
        end
      end
    end
  end
  always @(posedge clk) if (rnd_bp) begin
    #1 bus.out_ready = 1'($urandom_range(0, 1));
  end
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    @(posedge clk) #1;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.sub = s;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk) #1;
      n++;
    end
    if (!bus.in_ready) timeout("accept");
    @(posedge clk) #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk) #1;
      n++;
    end
    if (q.size() != 0) timeout("drain");
    @(posedge clk) #1;
  endtask
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, bus.in_ready, 1);
    chk({nm, "_out_valid"}, bus.out_valid, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_sum"}, bus.sum, 0);
    chk({nm, "_cout"}, bus.cout, 0);
    chk({nm, "_ovf"}, bus.ovf, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    @(posedge clk) #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) issue(da[i], db[i], ds[i]);
    drain();
    bus.out_ready = 1'b0;
    issue(16'h3C3C, 16'h1111, 1'b0);
    for (int n = 0; n < 50 && !bus.out_valid; n++) @(posedge clk) #1;
    if (!bus.out_valid) timeout("bp_out_valid");
    s0 = bus.sum;
    c0 = bus.cout;
    o0 = bus.ovf;
    bus.in_valid = 1'b1;
    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    bus.sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_sum_hold", bus.sum, s0);
      chk("bp_cout_hold", bus.cout, c0);
      chk("bp_ovf_hold", bus.ovf, o0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk) #1;
    chk("bp_idle_in_ready", bus.in_ready, 1);
    @(posedge clk) #1;
    bus.in_valid = 1'b0;
    chk("bp_accept_busy", bus.busy, 1);
    drain();
    bus.in_valid = 1'b1;
    bus.a = 16'h1234;
    bus.b = 16'h5678;
    bus.sub = 1'b1;
    @(posedge clk) #1;
    bus.in_valid = 1'b0;
    chk("run_busy", bus.busy, 1);
    @(posedge clk) #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrun_reset");
    q.delete();
    @(posedge clk) #1;
    rst_n = 1'b1;
    issue(16'h0F0F, 16'h0101, 1'b0);
    drain();
    rnd_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rnd_bp = 1'b0;
    #2;
    bus.out_ready = 1'b1;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencing controller that computes a W-bit add or subtract by driving one 4-bit ripple-carry adder slice for one nibble per clock cycle. The slice's carry-out is registered and fed back as the next nibble's carry-in. The block sits between a requester and a consumer, each with a valid/ready handshake. It trades latency for area: one shared 4-bit slice replaces a full-width adder.

## Interface
Parameters:
- NIBBLES, default 4: number of 4-bit slices per operation; W = 4*NIBBLES. Legal range 1..8.

Ports:
- clk  input  1  single clock, rising-edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  request present
- in_ready  output  1  controller can accept a request
- a  input  W  operand A
- b  input  W  operand B
- sub  input  1  1 = compute A-B, 0 = compute A+B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- sum  output  W  result
- cout  output  1  carry-out of the MSB slice. For subtract, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow
- busy  output  1  high in RUN or DONE

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE
  - in_ready=1.
  - On in_valid: capture opa<=a, opb<=(sub ? ~b : b), carry<=sub, cnt<=0.
  - Also record a_msb=a[W-1] and b_msb=opb[W-1].
  - Move to RUN.
- RUN: each cycle the slice adds opa[3:0], opb[3:0] and carry.
  - The 4-bit slice sum shifts into sum_r from the top: sum_r <= {slice_sum, sum_r[W-1:4]}.
  - opa and opb shift right by 4.
  - carry <= slice_cout.
  - cnt increments.
  - When cnt==NIBBLES-1, move to DONE.
- DONE
  - out_valid=1.
  - sum=sum_r, cout=carry.
  - ovf = (a_msb==b_msb) && (sum_r[W-1]!=a_msb).
  - On out_ready, move to IDLE.
- Arithmetic is modulo 2^W. Subtract is A + ~B + 1, using the same slice.
- Outputs (sum, cout, ovf) hold stable for the whole DONE state and keep their last value in IDLE and RUN. Consumers sample them only while out_valid=1.
- In RUN and DONE, in_valid is ignored: in_ready=0 and no capture occurs.
- The block does not accept a new request in the same cycle that a result is taken. The next acceptance happens in IDLE, one cycle after the out_ready handshake.

## Timing
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, cnt=0, carry=0.
- Reset is asynchronous. Asserting rst_n mid-RUN or mid-DONE aborts the operation at once. No result is produced for it.
- Latency: if a request is accepted at rising edge T, out_valid is high after edge T+NIBBLES (4 cycles for the default).
- Throughput: at best one result per NIBBLES+2 cycles, with out_ready held high.
- Backpressure: out_valid stays asserted, with stable data, until out_ready=1. There is no timeout.
- Handshakes complete on rising edges where valid&&ready=1.
- in_valid may drop before acceptance without error. The block has no combinational path from in_valid to in_ready or out_valid.

## Structure
- A shared package holds:
  - the state enum (IDLE, RUN, DONE)
  - the constant NIBBLE_W=4
  - a function for the count width, $clog2(NIBBLES) with a minimum of 1.
- One sub-module, nibble_adder_slice, is natural: a combinational 4-bit ripple-carry adder (a[3:0], b[3:0], cin -> sum[3:0], cout) built from four full-adder cells.
- The controller instantiates exactly one slice and contains all registers and the FSM.

## Test plan
All cases use NIBBLES=4.
- Plain add: a=0x1234, b=0x4321, sub=0 -> sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 cycles after acceptance.
- Full carry ripple: a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, ovf=0.
- Signed overflow:
  - a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1.
  - a=0x8000, b=0x0001, sub -> sum=0x7FFF, cout=1, ovf=1.
- Borrowing subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE.
  - out_valid, sum, cout and ovf stay constant; in_ready=0.
  - A concurrent in_valid with a=0xAAAA is not captured.
  - Releasing out_ready returns the block to IDLE, and the 0xAAAA request is then accepted.
- Reset mid-operation: assert rst_n=0 during the second RUN cycle.
  - All outputs go to their reset values immediately.
  - After release, a=0x0F0F, b=0x0101 add -> sum=0x1010 with no residue from the aborted operation.
